hazard_ctrl: RTL

Central hazard controller and scheduler for the 5-stage RV64I pipeline.
- Detects load-use hazards, branch/jump redirects and multi-cycle data-memory waits.
- Drives per-stage stall and flush controls. FlushE is the clr input of the D/E pipeline register.
- Selects the execute-stage operand forwarding paths.
- Runs a memory-wait state machine with a watchdog that latches a fatal error on a hung bus.

---
 rtl/hazard_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller and scheduler for the 5-stage RV64I pipeline.
//
// Responsibilities:
//   - Load-use detection, branch/jump redirect handling, data-memory waits.
//   - Per-stage stall and flush controls (FlushE clears the D/E register).
//   - Execute-stage operand forwarding selects.
//   - Memory-wait state machine with a watchdog that latches a sticky error
//     on a hung bus.
//
// Parameters:
//   MEM_TIMEOUT : MEM_WAIT cycles allowed before the watchdog fires
//                 (0 disables the watchdog)
//   CNT_W       : width of the performance counters
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   Rs1_D, Rs2_D                decode-stage source registers
//   Rs1_E, Rs2_E, Rd_E          execute-stage register fields
//   ResultSrc_E                 execute result select (2'b01 = load)
//   PCSrc_E                     redirect resolved in E
//   Rd_M, Rd_W                  destination registers in M and W
//   RegWrite_M, RegWrite_W      register write enables in M and W
//   dmem_req_M, dmem_ready      data-memory request / completion
//   StallF/D/E/M                hold the F, D, E and M registers
//   FlushD/E/W                  bubble into F/D, D/E and M/W registers
//   ForwardA_E, ForwardB_E      00 = regfile, 01 = W result, 10 = M ALU result
//   mem_busy                    FSM is in MEM_WAIT
//   mem_err                     sticky watchdog error
//   stall_cnt, flush_cnt        performance counters
//
// Build option:
//   HAZARD_PERF_CNT_EN : when defined, stall_cnt counts StallD cycles and
//   flush_cnt counts FlushD cycles (both saturating). When undefined no
//   counter flops exist and both ports read zero.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       ResultSrc_E,
  input  logic             PCSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  // Wide enough to hold MEM_TIMEOUT itself, at least one bit.
  localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic              WD_EN     = (MEM_TIMEOUT != 0);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              mem_err_r;
  logic              mem_err_nxt_s;
  logic              lw_stall_s;
  logic              mem_stall_s;

  // Forward select for one execute operand; the younger M result beats W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard terms and stall/flush controls; a memory stall overrides everything.
  always_comb begin
    lw_stall_s  = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                  ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    mem_stall_s = (state_r == ERR) || (dmem_req_M && !dmem_ready);
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall_s) begin
      // A pending redirect stays in frozen E and is applied on release.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall_s && !PCSrc_E;
      StallD = lw_stall_s && !PCSrc_E;
      FlushD = PCSrc_E;
      FlushE = PCSrc_E || lw_stall_s;
    end
  end

  // Operand forwarding selects.
  always_comb begin
    ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
    ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
  end

  // Memory-wait FSM next state, wait counter and watchdog.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    mem_err_nxt_s  = mem_err_r;
    case (state_r)
      RUN: begin
        if (dmem_req_M && !dmem_ready) begin
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        // Ready on the timeout cycle wins over the watchdog.
        if (dmem_ready) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else if (WD_EN && (wait_cnt_r == TIMEOUT_V)) begin
          state_nxt_s   = ERR;
          mem_err_nxt_s = 1'b1;
        end else if (wait_cnt_r != {WAIT_W{1'b1}}) begin
          wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          wait_cnt_nxt_s = wait_cnt_r;
        end
      end
      ERR: begin
        state_nxt_s = ERR;
      end
      default: begin
        // Unreachable encoding: fail safe into the frozen error state.
        state_nxt_s   = ERR;
        mem_err_nxt_s = 1'b1;
      end
    endcase
  end

  // FSM, wait counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= mem_err_nxt_s;
    end
  end

  assign mem_busy = (state_r == MEM_WAIT);
  assign mem_err  = mem_err_r;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating counters of decode-stall and decode-flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (StallD && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (FlushD && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
